// File: rtl/tt_um_spi_master.sv
// Mode-0 SPI master: LSB-first frames of DATAWIDTH bits, sclk half-period of HALF_PERIOD clks.
// Define SPI_MASTER_BUF_EN to add a one-word holding buffer for back-to-back frames.
module tt_um_spi_master #(
  parameter int unsigned DATAWIDTH   = 16,
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [DATAWIDTH-1:0] data_in,
  input  logic                 start,
  output logic                 ready,
  output logic                 done,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 nsel
);

  localparam int unsigned CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned BIT_W = $clog2(DATAWIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATAWIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATAWIDTH-1:0]   shift_q, shift_d;
  logic                   ready_d, done_d, sclk_d, mosi_d, nsel_d;
  logic                   accept;
  logic                   half_end;
  logic                   active;

`ifdef SPI_MASTER_BUF_EN
  logic [DATAWIDTH-1:0]   buf_q, buf_d;
  logic                   buf_valid_q, buf_valid_d;
`endif

  // Next-state, counters, shift register and registered-output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    accept   = start & ready;
    half_end = (cnt_q == CNT_MAX);
`ifdef SPI_MASTER_BUF_EN
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
`endif

    if (state_q != IDLE) begin
      cnt_d = half_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = data_in;
        end
      end
      SETUP: begin
        if (half_end) state_d = HIGH;
      end
      HIGH: begin
        if (half_end) begin
          state_d = LOW;
          bit_d   = bit_q + 1'b1;
          shift_d = shift_q >> 1;
        end
      end
      LOW: begin
        if (half_end) begin
          if (bit_q == BIT_LAST) begin
            state_d = GAP;
            done_d  = 1'b1;
          end else begin
            state_d = HIGH;
          end
        end
      end
      GAP: begin
        if (half_end) begin
          state_d = IDLE;
`ifdef SPI_MASTER_BUF_EN
          // Chain the held word straight into the next SETUP
          if (buf_valid_q) begin
            state_d     = SETUP;
            bit_d       = '0;
            shift_d     = buf_q;
            buf_valid_d = 1'b0;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SPI_MASTER_BUF_EN
    if (accept && (state_q != IDLE)) begin
      buf_d       = data_in;
      buf_valid_d = 1'b1;
    end
    ready_d = ~buf_valid_d;
`else
    ready_d = (state_d == IDLE);
`endif

    active = (state_d == SETUP) || (state_d == HIGH) || (state_d == LOW);
    nsel_d = ~active;
    sclk_d = (state_d == HIGH);
    mosi_d = active & shift_d[0];
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      nsel    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ready   <= ready_d;
      done    <= done_d;
      sclk    <= sclk_d;
      mosi    <= mosi_d;
      nsel    <= nsel_d;
    end
  end

`ifdef SPI_MASTER_BUF_EN
  // Holding buffer for a word accepted while a frame is in flight
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
    end
  end
`endif

endmodule
